// File: rtl/risk_check_controller.sv
// risk_check_controller
// Sequences the per-client risk RAM. Arbitrates max-limit configuration
// requests against order-check requests (cfg wins), runs one operation at a
// time so a read can never race a pending write, performs the read-modify-write
// of the client's accumulated total for orders, and keeps saturating
// accept/reject statistics.
module risk_check_controller #(
   parameter int D_WIDTH   = 32,
   parameter int A_WIDTH   = 10,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 order_valid,
   output logic                 order_ready,
   input  logic [A_WIDTH-1:0]   order_client,
   input  logic [D_WIDTH-1:0]   order_qty,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [A_WIDTH-1:0]   cfg_client,
   input  logic [D_WIDTH-1:0]   cfg_max,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_accept,
   output logic [A_WIDTH-1:0]   resp_client,
   output logic [A_WIDTH-1:0]   ram_address_read,
   input  logic [D_WIDTH-1:0]   ram_accumulated_orders,
   input  logic [D_WIDTH-1:0]   ram_max_to_trade,
   output logic [A_WIDTH-1:0]   ram_address_write,
   output logic [D_WIDTH-1:0]   ram_data_write,
   output logic                 ram_write_enable,
   output logic                 ram_change_max,
   output logic [CNT_WIDTH-1:0] accepted_count,
   output logic [CNT_WIDTH-1:0] rejected_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CFG  = 2'd1,
      EVAL = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_next_s;

   // Latched request: client and either the cfg max or the order quantity.
   logic [A_WIDTH-1:0]   client_r;
   logic [D_WIDTH-1:0]   data_r;

   logic                 resp_accept_r;
   logic [A_WIDTH-1:0]   resp_client_r;
   logic [CNT_WIDTH-1:0] accepted_count_r;
   logic [CNT_WIDTH-1:0] rejected_count_r;

   logic                 take_cfg_s;
   logic                 take_order_s;
   logic [D_WIDTH:0]     sum_s;
   logic                 accept_s;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   // Request acceptance and the order check; the extra sum bit catches carry-out.
   always_comb begin
      take_cfg_s   = (state_r == IDLE) && cfg_valid;
      take_order_s = (state_r == IDLE) && !cfg_valid && order_valid;
      sum_s        = {1'b0, ram_accumulated_orders} + {1'b0, data_r};
      accept_s     = (sum_s[D_WIDTH] == 1'b0) &&
                     (sum_s[D_WIDTH-1:0] <= ram_max_to_trade);
   end

   // Next-state logic: one operation in flight, cfg has priority in IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (cfg_valid) begin
               state_next_s = CFG;
            end else if (order_valid) begin
               state_next_s = EVAL;
            end else begin
               state_next_s = IDLE;
            end
         end
         CFG:  state_next_s = IDLE;
         EVAL: state_next_s = RESP;
         RESP: begin
            if (resp_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Capture the request being taken; held for the rest of the operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         client_r <= {A_WIDTH{1'b0}};
         data_r   <= {D_WIDTH{1'b0}};
      end else if (take_cfg_s) begin
         client_r <= cfg_client;
         data_r   <= cfg_max;
      end else if (take_order_s) begin
         client_r <= order_client;
         data_r   <= order_qty;
      end else begin
         client_r <= client_r;
         data_r   <= data_r;
      end
   end

   // Register the order result at the end of EVAL; stable throughout RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_accept_r <= 1'b0;
         resp_client_r <= {A_WIDTH{1'b0}};
      end else if (state_r == EVAL) begin
         resp_accept_r <= accept_s;
         resp_client_r <= client_r;
      end else begin
         resp_accept_r <= resp_accept_r;
         resp_client_r <= resp_client_r;
      end
   end

   // Saturating accept/reject statistics, bumped once per evaluated order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         accepted_count_r <= {CNT_WIDTH{1'b0}};
         rejected_count_r <= {CNT_WIDTH{1'b0}};
      end else if (state_r == EVAL) begin
         if (accept_s) begin
            if (accepted_count_r != CNT_MAX) begin
               accepted_count_r <= accepted_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               accepted_count_r <= accepted_count_r;
            end
         end else begin
            if (rejected_count_r != CNT_MAX) begin
               rejected_count_r <= rejected_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               rejected_count_r <= rejected_count_r;
            end
         end
      end else begin
         accepted_count_r <= accepted_count_r;
         rejected_count_r <= rejected_count_r;
      end
   end

   // Handshake and RAM port drive; everything that could act is gated by rst_n.
   always_comb begin
      order_ready       = 1'b0;
      cfg_ready         = 1'b0;
      resp_valid        = 1'b0;
      ram_address_read  = client_r;
      ram_address_write = {A_WIDTH{1'b0}};
      ram_data_write    = {D_WIDTH{1'b0}};
      ram_write_enable  = 1'b0;
      ram_change_max    = 1'b0;
      case (state_r)
         IDLE: begin
            // Read address goes out in the handshake cycle so data is ready in EVAL.
            ram_address_read = order_client;
            cfg_ready        = rst_n;
            order_ready      = rst_n && !cfg_valid;
         end
         CFG: begin
            ram_write_enable  = rst_n;
            ram_change_max    = 1'b1;
            ram_address_write = client_r;
            ram_data_write    = data_r;
         end
         EVAL: begin
            if (accept_s) begin
               ram_write_enable  = rst_n;
               ram_change_max    = 1'b0;
               ram_address_write = client_r;
               ram_data_write    = sum_s[D_WIDTH-1:0];
            end else begin
               ram_write_enable  = 1'b0;
            end
         end
         RESP: begin
            resp_valid = rst_n;
         end
         default: begin
            ram_write_enable = 1'b0;
         end
      endcase
   end

   assign resp_accept    = resp_accept_r;
   assign resp_client    = resp_client_r;
   assign accepted_count = accepted_count_r;
   assign rejected_count = rejected_count_r;

endmodule

// File: tb/tb_risk_check_controller.sv
// Testbench for risk_check_controller: behavioural risk RAM, directed
// stimulus, and a response scoreboard drained by an independent monitor.
module tb_risk_check_controller;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          order_valid, order_ready;
   logic [AW-1:0] order_client;
   logic [DW-1:0] order_qty;
   logic          cfg_valid, cfg_ready;
   logic [AW-1:0] cfg_client;
   logic [DW-1:0] cfg_max;
   logic          resp_valid, resp_ready, resp_accept;
   logic [AW-1:0] resp_client;
   logic [AW-1:0] ram_address_read, ram_address_write;
   logic [DW-1:0] ram_accumulated_orders, ram_max_to_trade, ram_data_write;
   logic          ram_write_enable, ram_change_max;
   logic [CW-1:0] accepted_count, rejected_count;

   int checks = 0;
   int failures = 0;
   int we_pulses = 0;

   typedef struct packed {
      logic          accept;
      logic [AW-1:0] client;
   } exp_t;
   exp_t exp_q[$];

   logic [DW-1:0] acc_mem [0:1023];
   logic [DW-1:0] max_mem [0:1023];

   risk_check_controller #(.D_WIDTH(DW), .A_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .order_valid(order_valid), .order_ready(order_ready),
      .order_client(order_client), .order_qty(order_qty),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_client(cfg_client), .cfg_max(cfg_max),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_accept(resp_accept), .resp_client(resp_client),
      .ram_address_read(ram_address_read),
      .ram_accumulated_orders(ram_accumulated_orders),
      .ram_max_to_trade(ram_max_to_trade),
      .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
      .ram_write_enable(ram_write_enable), .ram_change_max(ram_change_max),
      .accepted_count(accepted_count), .rejected_count(rejected_count)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         acc_mem[i] = 32'd0;
         max_mem[i] = 32'd0;
      end
   end

   // Upstream risk RAM: registered read, write selected by ram_change_max.
   always @(posedge clk) begin
      ram_accumulated_orders <= acc_mem[ram_address_read];
      ram_max_to_trade       <= max_mem[ram_address_read];
      if (ram_write_enable) begin
         if (ram_change_max) max_mem[ram_address_write] <= ram_data_write;
         else                acc_mem[ram_address_write] <= ram_data_write;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: counts write strobes and scores every completed response.
   always @(negedge clk) begin
      exp_t e;
      if (ram_write_enable) we_pulses++;
      if (resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=%0h/%0h expected=none", resp_accept, resp_client);
         end else begin
            e = exp_q.pop_front();
            check("resp_accept", resp_accept, e.accept);
            check("resp_client", resp_client, e.client);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cfg_ready) return;
      end
      check("idle_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_cfg(input logic [AW-1:0] c, input logic [DW-1:0] m);
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_client = c; cfg_max = m;
      @(negedge clk);
      check("cfg_ready", cfg_ready, 1'b1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("cfg_we", ram_write_enable, 1'b1);
      check("cfg_change_max", ram_change_max, 1'b1);
      check("cfg_addr", ram_address_write, c);
      check("cfg_data", ram_data_write, m);
      wait_idle();
   endtask

   // Ends at the first negedge of RESP.
   task automatic send_order(input logic [AW-1:0] c, input logic [DW-1:0] q,
                             input logic acc, input logic [DW-1:0] new_total);
      @(posedge clk); #1;
      order_valid = 1'b1; order_client = c; order_qty = q;
      @(negedge clk);
      check("order_ready", order_ready, 1'b1);
      check("rd_addr_idle", ram_address_read, c);
      exp_q.push_back('{accept: acc, client: c});
      @(posedge clk); #1;
      order_valid = 1'b0;
      @(negedge clk);
      check("eval_resp_valid", resp_valid, 1'b0);
      check("eval_we", ram_write_enable, acc);
      if (acc) begin
         check("eval_change_max", ram_change_max, 1'b0);
         check("eval_addr", ram_address_write, c);
         check("eval_data", ram_data_write, new_total);
      end
      @(negedge clk);
      check("resp_valid_lat", resp_valid, 1'b1);
   endtask

   initial begin
      int p;
      rst_n = 1'b0; order_valid = 1'b0; order_client = 10'd0; order_qty = 32'd0;
      cfg_valid = 1'b0; cfg_client = 10'd0; cfg_max = 32'd0; resp_ready = 1'b1;

      // Reset behaviour
      repeat (3) @(negedge clk);
      check("rst_order_ready", order_ready, 1'b0);
      check("rst_cfg_ready", cfg_ready, 1'b0);
      check("rst_we", ram_write_enable, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_order_ready", order_ready, 1'b1);
      check("idle_cfg_ready", cfg_ready, 1'b1);
      check("idle_resp_valid", resp_valid, 1'b0);
      check("rst_acc_cnt", accepted_count, 32'd0);
      check("rst_rej_cnt", rejected_count, 32'd0);

      // Basic accumulate, equality accept, then reject
      send_cfg(10'd5, 32'd100);
      check("max5", max_mem[5], 32'd100);
      send_order(10'd5, 32'd60, 1'b1, 32'd60);
      wait_idle();
      check("acc5_60", acc_mem[5], 32'd60);
      check("acc_cnt_1", accepted_count, 32'd1);
      send_order(10'd5, 32'd40, 1'b1, 32'd100);
      wait_idle();
      check("acc5_100", acc_mem[5], 32'd100);
      p = we_pulses;
      send_order(10'd5, 32'd1, 1'b0, 32'd0);
      wait_idle();
      check("reject_no_write", we_pulses, p);
      check("acc5_kept", acc_mem[5], 32'd100);
      check("rej_cnt_1", rejected_count, 32'd1);
      check("acc_cnt_2", accepted_count, 32'd2);

      // cfg and order together: cfg first, order uses the new max
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_client = 10'd7; cfg_max = 32'd50;
      order_valid = 1'b1; order_client = 10'd7; order_qty = 32'd30;
      @(negedge clk);
      check("both_order_ready", order_ready, 1'b0);
      check("both_cfg_ready", cfg_ready, 1'b1);
      @(posedge clk); #1 cfg_valid = 1'b0;
      @(negedge clk);
      check("both_cfg_we", ram_write_enable, 1'b1);
      check("both_change_max", ram_change_max, 1'b1);
      check("both_cfg_data", ram_data_write, 32'd50);
      check("both_cfg_order_ready", order_ready, 1'b0);
      exp_q.push_back('{accept: 1'b1, client: 10'd7});
      @(negedge clk);
      check("both_order_ready2", order_ready, 1'b1);
      @(posedge clk); #1 order_valid = 1'b0;
      @(negedge clk);
      check("both_eval_we", ram_write_enable, 1'b1);
      check("both_eval_data", ram_data_write, 32'd30);
      wait_idle();
      check("max7", max_mem[7], 32'd50);
      check("acc7", acc_mem[7], 32'd30);

      // Overflow, qty=0 writeback, max=0 client
      send_cfg(10'd9, 32'hFFFF_FFFF);
      send_order(10'd9, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFF0);
      wait_idle();
      send_order(10'd9, 32'h0000_0020, 1'b0, 32'd0);
      wait_idle();
      send_order(10'd9, 32'd0, 1'b1, 32'hFFFF_FFF0);
      wait_idle();
      check("acc9", acc_mem[9], 32'hFFFF_FFF0);
      send_order(10'd3, 32'd1, 1'b0, 32'd0);
      wait_idle();
      check("acc_cnt_5", accepted_count, 32'd5);
      check("rej_cnt_3", rejected_count, 32'd3);

      // Backpressure: hold resp_ready low
      resp_ready = 1'b0;
      send_order(10'd12, 32'd0, 1'b1, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", resp_valid, 1'b1);
         check("hold_accept", resp_accept, 1'b1);
         check("hold_client", resp_client, 10'd12);
         check("hold_order_ready", order_ready, 1'b0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
      check("hold_release_valid", resp_valid, 1'b1);
      @(negedge clk);
      check("hold_done_ready", order_ready, 1'b1);
      check("acc_cnt_6", accepted_count, 32'd6);

      // Reset during an accepting EVAL
      send_cfg(10'd20, 32'd10);
      @(posedge clk); #1;
      order_valid = 1'b1; order_client = 10'd20; order_qty = 32'd5;
      @(posedge clk); #1;
      order_valid = 1'b0; rst_n = 1'b0;
      p = we_pulses;
      @(negedge clk);
      check("rst_eval_we", ram_write_enable, 1'b0);
      check("rst_eval_order_ready", order_ready, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_eval_resp_valid", resp_valid, 1'b0);
      check("rst_eval_idle", order_ready, 1'b1);
      check("rst_eval_acc_cnt", accepted_count, 32'd0);
      check("rst_eval_rej_cnt", rejected_count, 32'd0);
      check("rst_eval_no_write", we_pulses, p);
      check("acc20_untouched", acc_mem[20], 32'd0);
      send_order(10'd20, 32'd5, 1'b1, 32'd5);
      wait_idle();
      check("acc20", acc_mem[20], 32'd5);
      check("post_rst_acc_cnt", accepted_count, 32'd1);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
